// File: rtl/alu_regfile_pkg.sv
// Shared opcode definitions for the pipelined ALU/register-file datapath.
package alu_regfile_pkg;

    localparam int ALUOP_W = 3;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

endpackage

// File: rtl/alu_regfile_pipe_regfile_2r2w.sv
// Register array with two asynchronous read ports and two write ports.
// Port A (ALU writeback) beats port B (external) when both hit the same entry.
module regfile_2r2w #(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [WIDTH-1:0]  data_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [WIDTH-1:0]  data_b,
    input  logic [ADDR_W-1:0] ra1,
    output logic [WIDTH-1:0]  rd1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [WIDTH-1:0] mem_q [NUM_REGS];
    logic [WIDTH-1:0] mem_d [NUM_REGS];

    // Port A is applied last so it overrides port B on an address match.
    always_comb begin
        mem_d = mem_q;
        if (we_b) mem_d[addr_b] = data_b;
        if (we_a) mem_d[addr_a] = data_a;
        if (ZERO_REG) mem_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd1 = (ZERO_REG && ra1 == '0) ? '0 : mem_q[ra1];
    assign rd2 = (ZERO_REG && ra2 == '0) ? '0 : mem_q[ra2];

endmodule

// File: rtl/alu_regfile_pipe.sv
// Register file feeding a one-stage registered ALU with automatic writeback
// and a result bypass so dependent back-to-back operations never stall.
module alu_regfile_pipe
    import alu_regfile_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int ADDR_W   = 2,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWrite,
    input  logic [ADDR_W-1:0]  WriteAddr,
    input  logic [WIDTH-1:0]   WriteData,
    input  logic [ADDR_W-1:0]  ReadAddr1,
    input  logic [ADDR_W-1:0]  ReadAddr2,
    input  logic [WIDTH-1:0]   Instr_i,
    input  logic               ALUSrc1,
    input  logic               ALUSrc2,
    input  logic [ALUOP_W-1:0] ALUOp,
    input  logic               valid_i,
    input  logic               WbEn,
    input  logic [ADDR_W-1:0]  WbAddr,
    output logic [WIDTH-1:0]   input1,
    output logic [WIDTH-1:0]   input2,
    output logic [WIDTH-1:0]   result,
    output logic               valid_o,
    output logic               ovf,
    output logic               zero,
    output logic               take_branch
);

    alu_op_e           op;
    logic [WIDTH-1:0]  rd1, rd2;
    logic [WIDTH-1:0]  sum, diff, alu_res;
    logic              alu_ovf, alu_branch;
    logic              wb_live, byp1, byp2;

    logic [WIDTH-1:0]  result_q, result_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;
    logic              zero_q, zero_d;
    logic              branch_q, branch_d;
    logic              wb_en_q, wb_en_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;

    assign op = alu_op_e'(ALUOp);

    regfile_2r2w #(
        .WIDTH   (WIDTH),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(ZERO_REG)
    ) u_regfile (
        .clk   (clk),
        .rst_n (rst),
        .we_a  (wb_en_q),
        .addr_a(wb_addr_q),
        .data_a(result_q),
        .we_b  (RegWrite),
        .addr_b(WriteAddr),
        .data_b(WriteData),
        .ra1   (ReadAddr1),
        .rd1   (rd1),
        .ra2   (ReadAddr2),
        .rd2   (rd2)
    );

    // A writeback into a hard-wired zero register never lands, so never forward it.
    assign wb_live = wb_en_q && !(ZERO_REG && wb_addr_q == '0);
    assign byp1    = wb_live && (ReadAddr1 == wb_addr_q);
    assign byp2    = wb_live && (ReadAddr2 == wb_addr_q);

    assign input1 = ALUSrc1 ? Instr_i : (byp1 ? result_q : rd1);
    assign input2 = ALUSrc2 ? Instr_i : (byp2 ? result_q : rd2);

    assign sum  = input1 + input2;
    assign diff = input1 - input2;

    always_comb begin
        alu_res    = '0;
        alu_ovf    = 1'b0;
        alu_branch = (op == ALU_SUB) && (input1 == input2);
        case (op)
            ALU_ADD: begin
                alu_res = sum;
                alu_ovf = (input1[WIDTH-1] == input2[WIDTH-1]) && (sum[WIDTH-1] != input1[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_res = diff;
                alu_ovf = (input1[WIDTH-1] != input2[WIDTH-1]) && (diff[WIDTH-1] != input1[WIDTH-1]);
            end
            ALU_AND: alu_res = input1 & input2;
            ALU_OR:  alu_res = input1 | input2;
            ALU_XOR: alu_res = input1 ^ input2;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) < $signed(input2))};
            ALU_SLL: alu_res = input1 << input2[2:0];
            ALU_SRL: alu_res = input1 >> input2[2:0];
            default: alu_res = '0;
        endcase
    end

    // Idle cycles keep the last result and flags but never schedule a writeback.
    always_comb begin
        result_d  = result_q;
        ovf_d     = ovf_q;
        zero_d    = zero_q;
        branch_d  = branch_q;
        wb_addr_d = wb_addr_q;
        valid_d   = valid_i;
        wb_en_d   = 1'b0;
        if (valid_i) begin
            result_d  = alu_res;
            ovf_d     = alu_ovf;
            zero_d    = (alu_res == '0);
            branch_d  = alu_branch;
            wb_en_d   = WbEn;
            wb_addr_d = WbAddr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q  <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            zero_q    <= 1'b0;
            branch_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
        end else begin
            result_q  <= result_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            zero_q    <= zero_d;
            branch_q  <= branch_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
        end
    end

    assign result      = result_q;
    assign valid_o     = valid_q;
    assign ovf         = ovf_q;
    assign zero        = zero_q;
    assign take_branch = branch_q;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Directed bench for alu_regfile_pipe: a default 8-bit instance and a
// 16-bit, 8-register instance with the hard-wired zero register.
module tb_alu_regfile_pipe;
    import alu_regfile_pkg::*;

    logic clk;
    logic rst;

    logic        p8_reg_write, p8_src1, p8_src2, p8_valid_i, p8_wb_en;
    logic [1:0]  p8_write_addr, p8_ra1, p8_ra2, p8_wb_addr;
    logic [7:0]  p8_write_data, p8_instr, p8_in1, p8_in2, p8_result;
    logic [2:0]  p8_op;
    logic        p8_valid_o, p8_ovf, p8_zero, p8_branch;

    logic        p16_reg_write, p16_src1, p16_src2, p16_valid_i, p16_wb_en;
    logic [2:0]  p16_write_addr, p16_ra1, p16_ra2, p16_wb_addr;
    logic [15:0] p16_write_data, p16_instr, p16_in1, p16_in2, p16_result;
    logic [2:0]  p16_op;
    logic        p16_valid_o, p16_ovf, p16_zero, p16_branch;

    int tests_run    = 0;
    int tests_failed = 0;

    alu_regfile_pipe dut8 (
        .clk(clk), .rst(rst),
        .RegWrite(p8_reg_write), .WriteAddr(p8_write_addr), .WriteData(p8_write_data),
        .ReadAddr1(p8_ra1), .ReadAddr2(p8_ra2), .Instr_i(p8_instr),
        .ALUSrc1(p8_src1), .ALUSrc2(p8_src2), .ALUOp(p8_op),
        .valid_i(p8_valid_i), .WbEn(p8_wb_en), .WbAddr(p8_wb_addr),
        .input1(p8_in1), .input2(p8_in2), .result(p8_result), .valid_o(p8_valid_o),
        .ovf(p8_ovf), .zero(p8_zero), .take_branch(p8_branch)
    );

    alu_regfile_pipe #(.WIDTH(16), .ADDR_W(3), .ZERO_REG(1'b1)) dut16 (
        .clk(clk), .rst(rst),
        .RegWrite(p16_reg_write), .WriteAddr(p16_write_addr), .WriteData(p16_write_data),
        .ReadAddr1(p16_ra1), .ReadAddr2(p16_ra2), .Instr_i(p16_instr),
        .ALUSrc1(p16_src1), .ALUSrc2(p16_src2), .ALUOp(p16_op),
        .valid_i(p16_valid_i), .WbEn(p16_wb_en), .WbAddr(p16_wb_addr),
        .input1(p16_in1), .input2(p16_in2), .result(p16_result), .valid_o(p16_valid_o),
        .ovf(p16_ovf), .zero(p16_zero), .take_branch(p16_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    task automatic p8_idle();
        p8_reg_write = 0; p8_write_addr = 0; p8_write_data = 0;
        p8_ra1 = 0; p8_ra2 = 0; p8_instr = 0; p8_src1 = 0; p8_src2 = 0;
        p8_op = ALU_ADD; p8_valid_i = 0; p8_wb_en = 0; p8_wb_addr = 0;
    endtask

    task automatic p16_idle();
        p16_reg_write = 0; p16_write_addr = 0; p16_write_data = 0;
        p16_ra1 = 0; p16_ra2 = 0; p16_instr = 0; p16_src1 = 0; p16_src2 = 0;
        p16_op = ALU_ADD; p16_valid_i = 0; p16_wb_en = 0; p16_wb_addr = 0;
    endtask

    // External write over one full cycle; returns at the following falling edge.
    task automatic p8_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        p8_reg_write = 1; p8_write_addr = a; p8_write_data = d;
        @(negedge clk);
        p8_reg_write = 0;
    endtask

    task automatic p16_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        p16_reg_write = 1; p16_write_addr = a; p16_write_data = d;
        @(negedge clk);
        p16_reg_write = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        p8_src1 = 1; p8_src2 = 1; p8_instr = 8'h05; p8_op = ALU_ADD;
        p8_valid_i = 1; p8_wb_en = 1; p8_wb_addr = 2'd1;
        @(negedge clk);
        tests_run++; if (p8_result !== 8'h0A || p8_valid_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_reset_add: got %h/%b expected 0a/1", p8_result, p8_valid_o); end
        p8_instr = 8'h07; p8_wb_addr = 2'd2;
        p8_reg_write = 1; p8_write_addr = 2'd3; p8_write_data = 8'h33;
        #1 rst = 0;
        #1;
        tests_run++; if (p8_valid_o !== 1'b0 || p8_result !== 8'h00) begin tests_failed++; $display("[TB] FAIL async_reset: got %h/%b expected 00/0", p8_result, p8_valid_o); end
        @(negedge clk);
        tests_run++; if (p8_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", p8_valid_o); end
        tests_run++; if (p8_result !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_result: got %h expected 00", p8_result); end
        tests_run++; if ({p8_ovf, p8_zero, p8_branch} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_flags: got %b expected 000", {p8_ovf, p8_zero, p8_branch}); end
        p8_idle();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            p8_ra1 = i[1:0];
            #1;
            tests_run++; if (p8_in1 !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_reg%0d: got %h expected 00", i, p8_in1); end
        end
    endtask

    task automatic test_imm_and();
        p8_write(2'd1, 8'hAB);
        p8_ra1 = 2'd1; p8_src1 = 0; p8_src2 = 1; p8_instr = 8'hA0; p8_op = ALU_AND;
        p8_valid_i = 1; p8_wb_en = 1; p8_wb_addr = 2'd2;
        #1;
        tests_run++; if (p8_in1 !== 8'hAB) begin tests_failed++; $display("[TB] FAIL and_operand: got %h expected ab", p8_in1); end
        @(negedge clk);
        p8_valid_i = 0; p8_wb_en = 0;
        tests_run++; if (p8_result !== 8'hA0) begin tests_failed++; $display("[TB] FAIL and_result: got %h expected a0", p8_result); end
        tests_run++; if (p8_valid_o !== 1'b1 || p8_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL and_valid_zero: got %b%b expected 10", p8_valid_o, p8_zero); end
        @(negedge clk);
        p8_ra1 = 2'd2;
        #1;
        tests_run++; if (p8_in1 !== 8'hA0) begin tests_failed++; $display("[TB] FAIL and_writeback: got %h expected a0", p8_in1); end
        tests_run++; if (p8_valid_o !== 1'b0 || p8_result !== 8'hA0) begin tests_failed++; $display("[TB] FAIL idle_hold: got %h/%b expected a0/0", p8_result, p8_valid_o); end
    endtask

    task automatic test_forward_ovf();
        p8_write(2'd1, 8'h7F);
        p8_ra1 = 2'd1; p8_src1 = 0; p8_src2 = 1; p8_instr = 8'h01; p8_op = ALU_ADD;
        p8_valid_i = 1; p8_wb_en = 1; p8_wb_addr = 2'd3;
        @(negedge clk);
        tests_run++; if (p8_result !== 8'h80 || p8_ovf !== 1'b1 || p8_zero !== 1'b0) begin tests_failed++; $display("[TB] FAIL add_ovf: got %h ovf=%b z=%b expected 80 ovf=1 z=0", p8_result, p8_ovf, p8_zero); end
        p8_ra1 = 2'd3; p8_ra2 = 2'd3; p8_src2 = 0; p8_wb_en = 0;
        #1;
        tests_run++; if (p8_in1 !== 8'h80 || p8_in2 !== 8'h80) begin tests_failed++; $display("[TB] FAIL bypass_operands: got %h %h expected 80 80", p8_in1, p8_in2); end
        @(negedge clk);
        p8_valid_i = 0;
        tests_run++; if (p8_result !== 8'h00 || p8_ovf !== 1'b1 || p8_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL bypass_add: got %h ovf=%b z=%b expected 00 ovf=1 z=1", p8_result, p8_ovf, p8_zero); end
        #1;
        tests_run++; if (p8_in1 !== 8'h80) begin tests_failed++; $display("[TB] FAIL r3_written: got %h expected 80", p8_in1); end
    endtask

    task automatic test_branch();
        p8_write(2'd1, 8'h11);
        p8_write(2'd2, 8'h22);
        p8_ra1 = 2'd1; p8_ra2 = 2'd1; p8_src1 = 0; p8_src2 = 0; p8_op = ALU_SUB;
        p8_valid_i = 1; p8_wb_en = 0;
        @(negedge clk);
        tests_run++; if (p8_branch !== 1'b1 || p8_zero !== 1'b1) begin tests_failed++; $display("[TB] FAIL branch_taken: got br=%b z=%b expected 1 1", p8_branch, p8_zero); end
        p8_ra2 = 2'd2;
        @(negedge clk);
        p8_valid_i = 0;
        tests_run++; if (p8_result !== 8'hEF) begin tests_failed++; $display("[TB] FAIL sub_result: got %h expected ef", p8_result); end
        tests_run++; if ({p8_branch, p8_zero, p8_ovf} !== 3'b000) begin tests_failed++; $display("[TB] FAIL branch_not_taken: got %b expected 000", {p8_branch, p8_zero, p8_ovf}); end
    endtask

    task automatic test_collision();
        @(negedge clk);
        p8_src1 = 1; p8_src2 = 1; p8_instr = 8'h1E; p8_op = ALU_ADD;
        p8_valid_i = 1; p8_wb_en = 1; p8_wb_addr = 2'd2;
        @(negedge clk);
        p8_valid_i = 0; p8_wb_en = 0;
        p8_reg_write = 1; p8_write_addr = 2'd2; p8_write_data = 8'h55;
        tests_run++; if (p8_result !== 8'h3C) begin tests_failed++; $display("[TB] FAIL collision_result: got %h expected 3c", p8_result); end
        @(negedge clk);
        p8_reg_write = 0; p8_ra1 = 2'd2; p8_src1 = 0; p8_src2 = 0;
        #1;
        tests_run++; if (p8_in1 !== 8'h3C) begin tests_failed++; $display("[TB] FAIL collision_same: got %h expected 3c", p8_in1); end
        p8_write(2'd2, 8'h01);
        p8_src1 = 1; p8_src2 = 1; p8_valid_i = 1; p8_wb_en = 1; p8_wb_addr = 2'd2;
        @(negedge clk);
        p8_valid_i = 0; p8_wb_en = 0;
        p8_reg_write = 1; p8_write_addr = 2'd3; p8_write_data = 8'h55;
        @(negedge clk);
        p8_reg_write = 0; p8_ra1 = 2'd2; p8_ra2 = 2'd3; p8_src1 = 0; p8_src2 = 0;
        #1;
        tests_run++; if (p8_in1 !== 8'h3C || p8_in2 !== 8'h55) begin tests_failed++; $display("[TB] FAIL collision_diff: got %h %h expected 3c 55", p8_in1, p8_in2); end
    endtask

    task automatic test_zero_reg();
        p16_write(3'd0, 16'hFFFF);
        p16_ra1 = 3'd0; p16_src1 = 0;
        #1;
        tests_run++; if (p16_in1 !== 16'h0000) begin tests_failed++; $display("[TB] FAIL r0_ext_write: got %h expected 0000", p16_in1); end
        @(negedge clk);
        p16_src1 = 1; p16_src2 = 1; p16_instr = 16'h1234; p16_op = ALU_ADD;
        p16_valid_i = 1; p16_wb_en = 1; p16_wb_addr = 3'd0;
        @(negedge clk);
        p16_valid_i = 0; p16_wb_en = 0; p16_ra1 = 3'd0; p16_src1 = 0; p16_src2 = 0;
        tests_run++; if (p16_result !== 16'h2468) begin tests_failed++; $display("[TB] FAIL r0_wb_result: got %h expected 2468", p16_result); end
        #1;
        tests_run++; if (p16_in1 !== 16'h0000) begin tests_failed++; $display("[TB] FAIL r0_no_bypass: got %h expected 0000", p16_in1); end
        @(negedge clk);
        #1;
        tests_run++; if (p16_in1 !== 16'h0000) begin tests_failed++; $display("[TB] FAIL r0_wb_dropped: got %h expected 0000", p16_in1); end
        p16_write(3'd1, 16'h8000);
        p16_ra1 = 3'd1; p16_src1 = 0; p16_src2 = 1; p16_instr = 16'h0003; p16_op = ALU_SRL;
        p16_valid_i = 1;
        @(negedge clk);
        p16_valid_i = 0;
        tests_run++; if (p16_result !== 16'h1000 || p16_ovf !== 1'b0) begin tests_failed++; $display("[TB] FAIL srl16: got %h ovf=%b expected 1000 ovf=0", p16_result, p16_ovf); end
        p16_write(3'd2, 16'hFFFF);
        p16_ra1 = 3'd2; p16_src1 = 0; p16_src2 = 1; p16_instr = 16'h0001; p16_op = ALU_SLT;
        p16_valid_i = 1;
        @(negedge clk);
        p16_valid_i = 0;
        tests_run++; if (p16_result !== 16'h0001) begin tests_failed++; $display("[TB] FAIL slt16: got %h expected 0001", p16_result); end
    endtask

    initial begin
        p8_idle();
        p16_idle();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_imm_and();
        test_forward_ovf();
        test_branch();
        test_collision();
        test_zero_reg();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
